icache_direct_mapped: RTL

//  Direct-mapped, read-only instruction cache between the IF stage and instruction memory.

---
 rtl/icache_direct_mapped_pkg.sv | 22 ++
 rtl/icache_direct_mapped_line_store.sv | 50 +++++
 rtl/icache_direct_mapped.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/icache_direct_mapped_pkg.sv
// Shared cache geometry, FSM state encoding and word-select helper for the
// direct-mapped instruction cache (and the future data cache).
package icache_direct_mapped_pkg;

   localparam int LINE_BYTES     = 32;
   localparam int OFFSET_W       = 5;
   localparam int WORD_SEL_W     = 3;
   localparam int WORDS_PER_LINE = 8;
   localparam int LINE_BITS      = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      ICS_IDLE = 2'd0,
      ICS_MISS = 2'd1,
      ICS_FILL = 2'd2
   } ics_state_e;

   function automatic logic [31:0] selectWord(input logic [LINE_BITS-1:0] line,
                                              input logic [WORD_SEL_W-1:0] sel);
      return line[int'(sel)*32 +: 32];
   endfunction

endpackage

// File: rtl/icache_direct_mapped_line_store.sv
// Valid/tag/data storage for the instruction cache: combinational read port,
// one write port and a global invalidate that clears every valid bit.
module icache_line_store
   import icache_direct_mapped_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int IDX_W     = 5,
   parameter int TAG_W     = 22
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_W-1:0]     rd_idx_i,
   output logic                 rd_valid_o,
   output logic [TAG_W-1:0]     rd_tag_o,
   output logic [LINE_BITS-1:0] rd_data_o,
   input  logic                 wr_en_i,
   input  logic [IDX_W-1:0]     wr_idx_i,
   input  logic [TAG_W-1:0]     wr_tag_i,
   input  logic [LINE_BITS-1:0] wr_data_i,
   input  logic                 wr_valid_i,
   input  logic                 inv_all_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_BITS-1:0] data_q [NUM_LINES];

   // Invalidate takes priority over a concurrent fill so the line stays invalid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (inv_all_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with single-block line fills.
// Define ICACHE_STATS_EN to add the Hit_count / Miss_count statistics ports.
module icache_direct_mapped
   import icache_direct_mapped_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int ADDR_W    = 32
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [ADDR_W-1:0]    Instr_address_2IC,
   output logic [31:0]          Instr1_fIC,
   output logic                 Instr_valid_fIC,
   input  logic                 Invalidate,
   output logic [ADDR_W-1:0]    Instr_address_2IM,
   output logic                 iBlkRead,
   input  logic [LINE_BITS-1:0] block_read_fIM,
   input  logic                 block_read_fIM_valid
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]          Hit_count,
   output logic [31:0]          Miss_count
`endif
);

   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_W - OFFSET_W - IDX_W;
   localparam int LINE_W = ADDR_W - OFFSET_W;

   ics_state_e          state_q, state_d;
   logic [LINE_W-1:0]   fillLine_q, fillLine_d;
   logic                invSeen_q, invSeen_d;

   logic [IDX_W-1:0]     fetchIdx;
   logic [TAG_W-1:0]     fetchTag;
   logic [WORD_SEL_W-1:0] wordSel;
   logic                 rdValid;
   logic [TAG_W-1:0]     rdTag;
   logic [LINE_BITS-1:0] rdData;
   logic                 tagMatch;
   logic                 hit;
   logic                 fillWrite;
   logic                 unusedAddrBits;

   assign fetchTag       = Instr_address_2IC[ADDR_W-1 -: TAG_W];
   assign fetchIdx       = Instr_address_2IC[OFFSET_W +: IDX_W];
   assign wordSel        = Instr_address_2IC[2 +: WORD_SEL_W];
   assign unusedAddrBits = ^Instr_address_2IC[1:0];

   icache_line_store #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_store (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .rd_idx_i   (fetchIdx),
      .rd_valid_o (rdValid),
      .rd_tag_o   (rdTag),
      .rd_data_o  (rdData),
      .wr_en_i    (fillWrite),
      .wr_idx_i   (fillLine_q[0 +: IDX_W]),
      .wr_tag_i   (fillLine_q[LINE_W-1 -: TAG_W]),
      .wr_data_i  (block_read_fIM),
      .wr_valid_i (!(Invalidate || invSeen_q)),
      .inv_all_i  (Invalidate)
   );

   assign tagMatch  = rdValid && (rdTag == fetchTag);
   assign hit       = (state_q == ICS_IDLE) && tagMatch && !Invalidate;
   assign fillWrite = (state_q == ICS_MISS) && block_read_fIM_valid;

   assign Instr_valid_fIC   = hit;
   assign Instr1_fIC        = hit ? selectWord(rdData, wordSel) : 32'h0;
   assign iBlkRead          = (state_q == ICS_MISS);
   assign Instr_address_2IM = {fillLine_q, {OFFSET_W{1'b0}}};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ICS_IDLE;
         fillLine_q <= '0;
         invSeen_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fillLine_q <= fillLine_d;
         invSeen_q  <= invSeen_d;
      end
   end

   // An invalidate seen at any point of a miss must leave the arriving line invalid.
   always_comb begin
      state_d    = state_q;
      fillLine_d = fillLine_q;
      invSeen_d  = invSeen_q;
      case (state_q)
         ICS_IDLE: begin
            if (!tagMatch) begin
               fillLine_d = Instr_address_2IC[ADDR_W-1:OFFSET_W];
               invSeen_d  = 1'b0;
               state_d    = ICS_MISS;
            end
         end
         ICS_MISS: begin
            if (Invalidate) begin
               invSeen_d = 1'b1;
            end
            if (block_read_fIM_valid) begin
               state_d = ICS_FILL;
            end
         end
         ICS_FILL: begin
            state_d = ICS_IDLE;
         end
         default: begin
            state_d = ICS_IDLE;
         end
      endcase
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hitCnt_q, missCnt_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hitCnt_q  <= '0;
         missCnt_q <= '0;
      end else begin
         if (hit) begin
            hitCnt_q <= hitCnt_q + 32'd1;
         end
         if ((state_q == ICS_IDLE) && (state_d == ICS_MISS)) begin
            missCnt_q <= missCnt_q + 32'd1;
         end
      end
   end

   assign Hit_count  = hitCnt_q;
   assign Miss_count = missCnt_q;
`endif

endmodule
